// File: rtl/dmem_arbiter_if.sv
// Bundle of MEM-stage, loader and data_memory signals shared by the arbiter and its environment.
// Each requester raises its request and holds it until completion (p_stall low, or l_ack high); the arbiter owns no backpressure beyond that.
interface dmem_arbiter_if;
  logic        p_read;
  logic        p_write;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic        p_stall;

  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [31:0] l_rdata;
  logic        l_ack;

  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  logic        busy;
  logic [1:0]  dbg_state;
  logic        dbg_grant;

  modport slave (
    input  p_read, p_write, p_addr, p_wdata,
    input  l_req, l_we, l_addr, l_wdata,
    input  dm_rdata,
    output p_rdata, p_stall, l_rdata, l_ack,
    output dm_read, dm_write, dm_addr, dm_wdata,
    output busy, dbg_state, dbg_grant
  );

  modport master (
    output p_read, p_write, p_addr, p_wdata,
    output l_req, l_we, l_addr, l_wdata,
    output dm_rdata,
    input  p_rdata, p_stall, l_rdata, l_ack,
    input  dm_read, dm_write, dm_addr, dm_wdata,
    input  busy, dbg_state, dbg_grant
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one wait-stated data memory between the MEM stage and a loader/debug port.
// Each access runs IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE (1 cycle) -> IDLE.
module dmem_arbiter #(
  parameter int WAIT_STATES = 2
) (
  input logic          clock,
  input logic          reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic       GRANT_P = 1'b0;
  localparam logic       GRANT_L = 1'b1;
  localparam logic [3:0] WS      = 4'(WAIT_STATES);

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic [3:0]  count;
  logic        op_write;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] p_rdata_q;
  logic [31:0] l_rdata_q;
  logic        dm_read_q;
  logic        dm_write_q;
  logic        l_ack_q;
  logic        busy_q;

  logic        p_req;
  logic        any_req;
  logic        pick;
  logic        pick_write;
  logic [31:0] pick_addr;
  logic [31:0] pick_wdata;

  assign p_req   = bus.p_read | bus.p_write;
  assign any_req = p_req | bus.l_req;

  // On a conflict the side that did not win last time gets the memory.
  always_comb begin
    pick       = GRANT_P;
    pick_write = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    if (p_req && bus.l_req) begin
      pick = ~last_grant;
    end else if (bus.l_req) begin
      pick = GRANT_L;
    end
    if (pick == GRANT_L) begin
      pick_write = bus.l_we;
      pick_addr  = bus.l_addr;
      pick_wdata = bus.l_wdata;
    end else begin
      pick_write = bus.p_write;
      pick_addr  = bus.p_addr;
      pick_wdata = bus.p_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= GRANT_L;
      last_grant <= GRANT_L;
      count      <= 4'd0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p_rdata_q  <= '0;
      l_rdata_q  <= '0;
      dm_read_q  <= 1'b0;
      dm_write_q <= 1'b0;
      l_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ACCESS;
            grant      <= pick;
            last_grant <= pick;
            op_write   <= pick_write;
            addr_q     <= pick_addr;
            wdata_q    <= pick_wdata;
            count      <= WS;
            dm_read_q  <= ~pick_write;
            dm_write_q <= pick_write;
            busy_q     <= 1'b1;
          end
        end
        ACCESS: begin
          if (count == 4'd0) begin
            state      <= DONE;
            dm_read_q  <= 1'b0;
            dm_write_q <= 1'b0;
            l_ack_q    <= (grant == GRANT_L);
            // Memory read data is valid on the last strobe cycle.
            if (!op_write) begin
              if (grant == GRANT_L) begin
                l_rdata_q <= bus.dm_rdata;
              end else begin
                p_rdata_q <= bus.dm_rdata;
              end
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          l_ack_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          dm_read_q  <= 1'b0;
          dm_write_q <= 1'b0;
          l_ack_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // The pipeline is released only in the cycle its own access completes.
  assign bus.p_stall   = p_req & ~((state == DONE) && (grant == GRANT_P));
  assign bus.p_rdata   = p_rdata_q;
  assign bus.l_rdata   = l_rdata_q;
  assign bus.l_ack     = l_ack_q;
  assign bus.dm_read   = dm_read_q;
  assign bus.dm_write  = dm_write_q;
  assign bus.dm_addr   = addr_q;
  assign bus.dm_wdata  = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state;
  assign bus.dbg_grant = grant;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 2, extra memory-busy cycles per access, legal range 0..15.
REQ-002 The block SHALL have port clock  input  1  system clock, rising-edge active.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port p_read  input  1  MEM-stage load request.
REQ-005 The block SHALL have port p_write  input  1  MEM-stage store request.
REQ-006 The block SHALL have port p_addr  input  32  MEM-stage address (ALU result).
REQ-007 The block SHALL have port p_wdata  input  32  MEM-stage store data.
REQ-008 The block SHALL have port p_rdata  output  32  load data returned to the MEM/WB register.
REQ-009 The block SHALL have port p_stall  output  1  pipeline freeze while the MEM-stage access is outstanding.
REQ-010 The block SHALL have port l_req  input  1  loader/debug port request.
REQ-011 The block SHALL have port l_we  input  1  loader write enable, 1 = write, 0 = read.
REQ-012 The block SHALL have port l_addr  input  32  loader address.
REQ-013 The block SHALL have port l_wdata  input  32  loader write data.
REQ-014 The block SHALL have port l_rdata  output  32  loader read data.
REQ-015 The block SHALL have port l_ack  output  1  one-cycle loader completion pulse.
REQ-016 The block SHALL have ports dm_read and dm_write  output  1 each  data_memory strobes.
REQ-017 The block SHALL have ports dm_addr and dm_wdata  output  32 each  data_memory address and write data.
REQ-018 The block SHALL have port dm_rdata  input  32  data_memory read result.
REQ-019 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 The block SHALL implement an FSM with states IDLE, ACCESS and DONE, plus a grant register (P/L), a last_grant register, and a 4-bit wait counter.
REQ-021 The MEM-stage request SHALL be p_read|p_write; when p_read and p_write are both high, the access SHALL be a write.
REQ-022 In IDLE with one requester, the block SHALL grant that requester; with both, it SHALL grant the requester not equal to last_grant (round-robin).
REQ-023 On grant, the block SHALL latch op/addr/wdata into internal registers, update last_grant, load the counter with WAIT_STATES and enter ACCESS on the next edge.
REQ-024 In ACCESS, dm_addr and dm_wdata SHALL come from the latched registers, with dm_read or dm_write held high every ACCESS cycle; both strobes SHALL be 0 in IDLE and DONE.
REQ-025 In ACCESS, the counter SHALL decrement each cycle; at counter==0, the block SHALL move to DONE, so ACCESS lasts WAIT_STATES+1 cycles.
REQ-026 On the ACCESS-to-DONE edge of a read, the block SHALL capture dm_rdata into p_rdata or l_rdata according to the grant; writes SHALL leave both rdata registers unchanged.
REQ-027 DONE SHALL last exactly one cycle and then return to IDLE; arbitration SHALL resume in that IDLE cycle.
REQ-028 l_ack SHALL be high only in DONE with grant L.
REQ-029 p_stall SHALL equal the MEM-stage request AND NOT (state==DONE AND grant==P), evaluated combinationally.
REQ-030 Latency SHALL be as follows: with a request in IDLE cycle T, DONE occurs at T+WAIT_STATES+2; for WAIT_STATES=2, p_stall is high in cycles T..T+3 and low in T+4.
REQ-031 Requesters SHALL hold the request until completion; a granted access whose request drops mid-flight SHALL still complete, and its ack/rdata SHALL still occur (no abort).
REQ-032 A request that appears while the block is not IDLE SHALL wait and SHALL be arbitrated in the next IDLE cycle.
REQ-033 Address and data changes on either port after grant SHALL NOT affect the access in flight.

Reset
REQ-034 While reset is low, the block SHALL force state=IDLE, counter=0, grant=L, last_grant=L, p_rdata=0, l_rdata=0, and dm_read=dm_write=l_ack=busy=0, taking effect asynchronously.
REQ-035 A reset assertion mid-ACCESS SHALL abandon the access, leave the rdata registers at 0, and produce no l_ack.
REQ-036 After reset release, the first simultaneous P/L conflict SHALL be granted to P.

Verification
REQ-037 The bench SHALL check this scenario: WAIT_STATES=2, p_read with p_addr=0x10 and memory[0x10]=0xDEADBEEF -> dm_read high 3 cycles, p_stall high 4 cycles, p_rdata=0xDEADBEEF in the cycle p_stall falls.
REQ-038 The bench SHALL check this scenario: l_req with l_we=1, l_addr=0x20, l_wdata=0x12345678 -> dm_write high 3 cycles with dm_addr=0x20, a one-cycle l_ack, and a subsequent loader read of 0x20 returns 0x12345678.
REQ-039 The bench SHALL check this scenario: p_read and l_req asserted in the same cycle after reset -> P is served first and L is granted in the IDLE cycle after P's DONE; with both held continuously, grants alternate P, L, P.
REQ-040 The bench SHALL check this scenario: p_read and p_write both high -> a write is performed and p_rdata is unchanged.
REQ-041 The bench SHALL check this scenario: reset driven low during the second ACCESS cycle -> the strobes drop without waiting for a clock edge, state=IDLE, no l_ack, and the rdata registers read 0.
REQ-042 The bench SHALL check this scenario: WAIT_STATES=0 -> a single ACCESS cycle and p_stall high for exactly 2 cycles.
